flash_responder: RTL and testbench

Synthesizable Avalon-MM read responder that stands in for the on-board flash controller IP, answering the `flash_mem_*` requests issued by flash reader/initiator blocks. It inserts a configurable number of wait states, accepts single or burst reads, and returns data from an internal word array after a configurable latency. It drops into the top-level wherever the flash IP instance sits, so initiators can be exercised in simulation or on-chip without the real device.

---
 rtl/flash_responder.sv | 160 ++++++++++++++++
 tb/tb_flash_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/flash_responder.sv
// Avalon-MM read responder standing in for the on-board flash controller IP.
// Define FLASH_RESPONDER_WRITE_EN to make accepted writes update the backing array.
//
// state  | meaning
// IDLE   | waiting for read or write
// WAIT   | waitrequest held high, counting wait states
// ACCEPT | one-cycle accept window, waitrequest low
// LAT    | read accepted, counting latency before the first beat
// BURST  | returning one beat per cycle
module flash_responder #(
  parameter int WAIT_CYCLES  = 2,
  parameter int READ_LATENCY = 1,
  parameter int DEPTH        = 256
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        flash_mem_read,
  input  logic        flash_mem_write,
  input  logic [22:0] flash_mem_address,
  input  logic [6:0]  flash_mem_burstcount,
  input  logic [3:0]  flash_mem_byteenable,
  input  logic [31:0] flash_mem_writedata,
  output logic        flash_mem_waitrequest,
  output logic [31:0] flash_mem_readdata,
  output logic        flash_mem_readdatavalid
);

  typedef enum logic [2:0] {IDLE, WAIT, ACCEPT, LAT, BURST} state_t;

  localparam int CW = 16;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [22:0]   r_addr;
  logic [6:0]    r_len;
  logic [6:0]    r_beat;
  logic          r_waitrequest;
  logic          r_readdatavalid;
  logic [31:0]   r_readdata;

  logic          w_req;
  logic          w_last_beat;
  logic [22:0]   w_beat_addr;
  logic          w_beat_in_range;
  logic [31:0]   w_beat_data;

  assign w_req           = flash_mem_read | flash_mem_write;
  assign w_beat_addr     = r_addr + {16'd0, r_beat};
  assign w_beat_in_range = (32'(w_beat_addr) < 32'(DEPTH));
  assign w_last_beat     = (r_beat == (r_len - 7'd1));

`ifdef FLASH_RESPONDER_WRITE_EN
  function automatic logic [DEPTH-1:0][31:0] f_mem_init();
    logic [DEPTH-1:0][31:0] m;
    for (int i = 0; i < DEPTH; i++) m[i] = 32'(i);
    return m;
  endfunction

  // Power-up contents come from the initialiser; reset never touches the array.
  logic [DEPTH-1:0][31:0] r_mem = f_mem_init();

  always_ff @(posedge clk_clk) begin
    if (!reset_reset && r_state == ACCEPT && flash_mem_write && !flash_mem_read
        && (32'(flash_mem_address) < 32'(DEPTH))) begin
      for (int i = 0; i < 4; i++) begin
        if (flash_mem_byteenable[i])
          r_mem[flash_mem_address[AW-1:0]][8*i +: 8] <= flash_mem_writedata[8*i +: 8];
      end
    end
  end

  assign w_beat_data = w_beat_in_range ? r_mem[w_beat_addr[AW-1:0]] : 32'h0;
`else
  logic w_unused_wr;
  assign w_unused_wr = ^{flash_mem_byteenable, flash_mem_writedata};
  assign w_beat_data = w_beat_in_range ? {9'd0, w_beat_addr} : 32'h0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_cnt_nxt   = CW'(WAIT_CYCLES);
          w_state_nxt = (WAIT_CYCLES == 0) ? ACCEPT : WAIT;
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) w_state_nxt = ACCEPT;
        end
      end
      ACCEPT: begin
        w_cnt_nxt = '0;
        if (flash_mem_read) begin
          // A latency of one means the first beat follows the very next edge.
          if (READ_LATENCY <= 1) begin
            w_state_nxt = BURST;
          end else begin
            w_state_nxt = LAT;
            w_cnt_nxt   = CW'(READ_LATENCY - 1);
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      LAT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt <= CW'(1)) w_state_nxt = BURST;
      end
      BURST: begin
        if (w_last_beat) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_addr          <= '0;
      r_len           <= '0;
      r_beat          <= '0;
      r_waitrequest   <= 1'b1;
      r_readdatavalid <= 1'b0;
      r_readdata      <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_cnt           <= w_cnt_nxt;
      r_waitrequest   <= (w_state_nxt != ACCEPT);
      r_readdatavalid <= 1'b0;
      r_readdata      <= '0;
      if (r_state == ACCEPT && flash_mem_read) begin
        r_addr <= flash_mem_address;
        r_len  <= (flash_mem_burstcount == 7'd0) ? 7'd1 : flash_mem_burstcount;
        r_beat <= '0;
      end
      if (r_state == BURST) begin
        r_readdatavalid <= 1'b1;
        r_readdata      <= w_beat_data;
        r_beat          <= r_beat + 7'd1;
      end
    end
  end

  assign flash_mem_waitrequest   = r_waitrequest;
  assign flash_mem_readdata      = r_readdata;
  assign flash_mem_readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_flash_responder.sv
// Directed self-checking bench for flash_responder (WAIT_CYCLES=2, READ_LATENCY=1, DEPTH=256).
// Expected write-back behaviour follows FLASH_RESPONDER_WRITE_EN when the bench is built with it.
module tb_flash_responder;

  localparam int WAIT_CYCLES  = 2;
  localparam int READ_LATENCY = 1;
  localparam int DEPTH        = 256;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        rd;
  logic        wr;
  logic [22:0] addr;
  logic [6:0]  bcount;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        waitreq;
  logic [31:0] rdata;
  logic        rvalid;

  flash_responder #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .READ_LATENCY(READ_LATENCY),
    .DEPTH       (DEPTH)
  ) dut (
    .clk_clk                (clk_clk),
    .reset_reset            (reset_reset),
    .flash_mem_read         (rd),
    .flash_mem_write        (wr),
    .flash_mem_address      (addr),
    .flash_mem_burstcount   (bcount),
    .flash_mem_byteenable   (be),
    .flash_mem_writedata    (wdata),
    .flash_mem_waitrequest  (waitreq),
    .flash_mem_readdata     (rdata),
    .flash_mem_readdatavalid(rvalid)
  );

  always #5 clk_clk = ~clk_clk;

  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  logic [31:0] q_beats[$];
  int          q_cyc[$];
  int          wl_cnt  = 0;
  int          idle_nz = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] mem3    = 32'd3;

  always @(negedge clk_clk) begin
    if (rvalid) begin
      q_beats.push_back(rdata);
      q_cyc.push_back(cyc);
    end else if (rdata != 32'h0) begin
      idle_nz++;
    end
    if (!waitreq) wl_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_clk);
    #1;
  endtask

  task automatic clear_mon();
    q_beats.delete();
    q_cyc.delete();
    wl_cnt = 0;
  endtask

  function automatic logic [31:0] mdl(input logic [22:0] a);
    if (a == 23'd3) return mem3;
    if (32'(a) < 32'(DEPTH)) return {9'd0, a};
    return 32'h0;
  endfunction

  task automatic handshake(input logic r, input logic w, input logic [22:0] a,
                           input logic [6:0] bc, input logic [31:0] d, input logic [3:0] ben,
                           output int t_req, output int wl, output bit ok);
    tick();
    rd = r; wr = w; addr = a; bcount = bc; wdata = d; be = ben;
    t_req = cyc + 1;
    wl = 0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!waitreq) begin
        wl = cyc;
        ok = 1'b1;
        break;
      end
    end
    tick();
    rd = 1'b0; wr = 1'b0; addr = '0; bcount = '0; wdata = '0; be = '0;
  endtask

  task automatic do_xfer(input string tag, input logic r, input logic w, input logic [22:0] a,
                         input logic [6:0] bc, input logic [31:0] d, input logic [3:0] ben);
    int t_req, wl, n;
    bit ok;
    logic [22:0] ba;
    clear_mon();
    handshake(r, w, a, bc, d, ben, t_req, wl, ok);
    check({tag, " accepted"}, 32'(ok), 32'd1);
    check({tag, " wait delay"}, 32'(wl - t_req), 32'(WAIT_CYCLES));
    n = !r ? 0 : ((bc == 7'd0) ? 1 : int'(bc));
    repeat (n + READ_LATENCY + 6) tick();
    check({tag, " beats"}, 32'(q_beats.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      ba = a + 23'(k);
      check($sformatf("%s beat%0d", tag, k),
            (q_beats.size() > k) ? q_beats[k] : 32'hDEADBEEF, mdl(ba));
    end
    if (n > 0 && q_cyc.size() == n) begin
      check({tag, " first beat latency"}, 32'(q_cyc[0] - wl), 32'(1 + READ_LATENCY));
      check({tag, " contiguous"}, 32'(q_cyc[n-1] - q_cyc[0]), 32'(n - 1));
    end
    check({tag, " waitreq low cycles"}, 32'(wl_cnt), 32'd1);
  endtask

  initial begin
    int t_req, wl;
    bit ok;
    reset_reset = 1'b1;
    rd = 1'b0; wr = 1'b0; addr = '0; bcount = '0; wdata = '0; be = '0;
    repeat (3) tick();
    check("reset waitreq", 32'(waitreq), 32'd1);
    check("reset valid", 32'(rvalid), 32'd0);
    check("reset rdata", rdata, 32'h0);
    reset_reset = 1'b0;
    tick();

    do_xfer("rd5", 1'b1, 1'b0, 23'd5, 7'd1, 32'h0, 4'h0);
    check("idle valid", 32'(rvalid), 32'd0);
    check("idle rdata", rdata, 32'h0);

    do_xfer("burst10", 1'b1, 1'b0, 23'd10, 7'd4, 32'h0, 4'h0);
    do_xfer("burst254", 1'b1, 1'b0, 23'd254, 7'd4, 32'h0, 4'h0);
    do_xfer("bc0_rd7", 1'b1, 1'b0, 23'd7, 7'd0, 32'h0, 4'h0);

    // Read held for one sampled edge only, then dropped while in WAIT.
    clear_mon();
    tick();
    rd = 1'b1; addr = 23'd50; bcount = 7'd1;
    tick();
    rd = 1'b0;
    repeat (8) tick();
    check("drop waitreq low cycles", 32'(wl_cnt), 32'd0);
    check("drop beats", 32'(q_beats.size()), 32'd0);

    // Burst of 8 cut by reset once three beats have arrived.
    clear_mon();
    handshake(1'b1, 1'b0, 23'd100, 7'd8, 32'h0, 4'h0, t_req, wl, ok);
    check("rstburst accepted", 32'(ok), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (q_beats.size() >= 3) break;
      tick();
    end
    reset_reset = 1'b1;
    tick();
    check("rstburst valid in reset", 32'(rvalid), 32'd0);
    check("rstburst waitreq in reset", 32'(waitreq), 32'd1);
    tick();
    reset_reset = 1'b0;
    repeat (12) tick();
    check("rstburst beats", 32'(q_beats.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      check($sformatf("rstburst beat%0d", k),
            (q_beats.size() > k) ? q_beats[k] : 32'hDEADBEEF, 32'(100 + k));
    check("rstburst waitreq low cycles", 32'(wl_cnt), 32'd1);

    do_xfer("wr3", 1'b0, 1'b1, 23'd3, 7'd1, 32'hAABBCCDD, 4'b0101);
`ifdef FLASH_RESPONDER_WRITE_EN
    mem3 = 32'h00BB00DD;
`endif
    do_xfer("rd3", 1'b1, 1'b0, 23'd3, 7'd1, 32'h0, 4'h0);

    do_xfer("rdwr20", 1'b1, 1'b1, 23'd20, 7'd1, 32'hFFFFFFFF, 4'b1111);
    do_xfer("rd20", 1'b1, 1'b0, 23'd20, 7'd1, 32'h0, 4'h0);

    check("rdata zero when not valid", 32'(idle_nz), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
